// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared timing constants, colour constants, position type and
//             command FSM encoding for the VGA pixel-generation stage.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Timing-controller mapping and visible screen size
  localparam int HOR_OFFSET = 40;
  localparam int VER_OFFSET = 1;
  localparam int SCREEN_W   = 800;
  localparam int SCREEN_H   = 600;

  // Pixel format: {R[3:0], G[3:0], B[3:0]}
  localparam int RGB_W = 12;

  localparam logic [RGB_W-1:0] BLACK    = 12'h000;
  localparam logic [RGB_W-1:0] BG_COLOR = 12'h00F;
  localparam logic [RGB_W-1:0] WHITE    = 12'hFFF;

  // Screen coordinates and box positions share one signed width so that
  // subtraction of the offsets and delta arithmetic never needs resizing.
  localparam int POS_W = 13;
  typedef logic signed [POS_W-1:0] pos_t;

  // Command FSM encoding
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cmd_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pos_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pos_clamp
//  Purpose  : Combinational signed add of an 8-bit delta to a box coordinate,
//             saturating the result to 0..MAX_POS so the box never wraps.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pos_clamp
  import vga_pkg::*;
#(
  parameter int MAX_POS = 768
) (
  input  pos_t              i_pos,
  input  logic signed [7:0] i_delta,
  output pos_t              o_pos
);

  localparam pos_t c_zero = '0;
  localparam pos_t c_max  = pos_t'(MAX_POS);

  pos_t w_delta_ext;
  pos_t w_sum;

  // Sign-extend the delta, add, then saturate at both screen edges
  always_comb begin
    w_delta_ext = {{(POS_W-8){i_delta[7]}}, i_delta};
    w_sum       = i_pos + w_delta_ext;
    if (w_sum < c_zero) begin
      o_pos = c_zero;
    end else if (w_sum > c_max) begin
      o_pos = c_max;
    end else begin
      o_pos = w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_box_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_box_renderer
//  Purpose  : Draws one solid rectangle over a background colour, two-stage
//             pixel pipeline behind the VGA timing controller. Box moves and
//             recolours via a valid/ready command that is applied only at
//             frame start so the box never tears mid-frame.
//  Revision : 1.0  initial release
// ============================================================================
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int               BOX_W      = 32,
  parameter int               BOX_H      = 32,
  parameter int               INIT_X     = 384,
  parameter int               INIT_Y     = 284,
  parameter logic [RGB_W-1:0] INIT_COLOR = WHITE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       display_col,
  input  logic [10:0]       display_row,
  input  logic              visible,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic signed [7:0] cmd_dx,
  input  logic signed [7:0] cmd_dy,
  input  logic [RGB_W-1:0]  cmd_color,
  output logic [RGB_W-1:0]  rgb,
  output logic              rgb_valid,
  output logic              frame_applied
);

  localparam pos_t c_zero     = '0;
  localparam pos_t c_hor_off  = pos_t'(HOR_OFFSET);
  localparam pos_t c_ver_off  = pos_t'(VER_OFFSET);
  localparam pos_t c_screen_w = pos_t'(SCREEN_W);
  localparam pos_t c_screen_h = pos_t'(SCREEN_H);
  localparam pos_t c_box_w    = pos_t'(BOX_W);
  localparam pos_t c_box_h    = pos_t'(BOX_H);
  localparam pos_t c_init_x   = pos_t'(INIT_X);
  localparam pos_t c_init_y   = pos_t'(INIT_Y);

  // Command / box state
  cmd_state_t        r_state;
  logic signed [7:0] r_pend_dx;
  logic signed [7:0] r_pend_dy;
  logic [RGB_W-1:0]  r_pend_color;
  pos_t              r_pos_x;
  pos_t              r_pos_y;
  logic [RGB_W-1:0]  r_color;

  // Pixel pipeline stage 1
  logic r_s1_in_screen;
  logic r_s1_in_box;
  logic r_s1_visible;

  logic w_frame_start;
  pos_t w_next_x;
  pos_t w_next_y;
  pos_t w_x;
  pos_t w_y;
  logic w_in_screen;
  logic w_in_box;

  assign w_frame_start = (display_col == 12'd1) && (display_row == 11'd1);

  vga_pos_clamp #(
    .MAX_POS (SCREEN_W - BOX_W)
  ) u_clamp_x (
    .i_pos   (r_pos_x),
    .i_delta (r_pend_dx),
    .o_pos   (w_next_x)
  );

  vga_pos_clamp #(
    .MAX_POS (SCREEN_H - BOX_H)
  ) u_clamp_y (
    .i_pos   (r_pos_y),
    .i_delta (r_pend_dy),
    .o_pos   (w_next_y)
  );

  // Command FSM: capture one command, hold it until the next frame start
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      cmd_ready     <= 1'b1;
      frame_applied <= 1'b0;
      r_pend_dx     <= '0;
      r_pend_dy     <= '0;
      r_pend_color  <= '0;
      r_pos_x       <= c_init_x;
      r_pos_y       <= c_init_y;
      r_color       <= INIT_COLOR;
    end else begin
      frame_applied <= 1'b0;
      case (r_state)
        IDLE: begin
          // A command accepted on a frame-start cycle waits for the next one
          if (cmd_valid) begin
            r_pend_dx    <= cmd_dx;
            r_pend_dy    <= cmd_dy;
            r_pend_color <= cmd_color;
            cmd_ready    <= 1'b0;
            r_state      <= PENDING;
          end
        end
        PENDING: begin
          if (w_frame_start) begin
            r_pos_x       <= w_next_x;
            r_pos_y       <= w_next_y;
            r_color       <= r_pend_color;
            frame_applied <= 1'b1;
            cmd_ready     <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Screen coordinates and region decode for the incoming pixel
  always_comb begin
    w_x         = pos_t'({1'b0, display_col}) - c_hor_off;
    w_y         = pos_t'({2'b00, display_row}) - c_ver_off;
    w_in_screen = visible &&
                  (w_x >= c_zero) && (w_x < c_screen_w) &&
                  (w_y >= c_zero) && (w_y < c_screen_h);
    w_in_box    = (w_x >= r_pos_x) && (w_x < r_pos_x + c_box_w) &&
                  (w_y >= r_pos_y) && (w_y < r_pos_y + c_box_h);
  end

  // Stage 1: register region flags and the active-video flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_in_screen <= 1'b0;
      r_s1_in_box    <= 1'b0;
      r_s1_visible   <= 1'b0;
    end else begin
      r_s1_in_screen <= w_in_screen;
      r_s1_in_box    <= w_in_box;
      r_s1_visible   <= visible;
    end
  end

  // Stage 2: select the pixel colour; black outside the visible screen
  always_ff @(posedge clock) begin
    if (reset) begin
      rgb       <= BLACK;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= r_s1_visible;
      if (!r_s1_in_screen) begin
        rgb <= BLACK;
      end else if (r_s1_in_box) begin
        rgb <= r_color;
      end else begin
        rgb <= BG_COLOR;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing controller.
- Consumes display_col, display_row and visible; outputs 12-bit RGB (4:4:4) for one solid rectangle on a background colour.
- Box position and colour change through a valid/ready command port. Accepted commands take effect only at a frame start, so the box never tears mid-frame.
- Output is pipelined, with a 2-cycle latency matched by rgb_valid.

Parameters:
- HOR_OFFSET, 40, display_col value that maps to screen x = 0
- VER_OFFSET, 1, display_row value that maps to screen y = 0
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- BOX_W, 32, box width in pixels
- BOX_H, 32, box height in pixels
- INIT_X, 384, box left edge after reset
- INIT_Y, 284, box top edge after reset
- INIT_COLOR, 12'hFFF, box colour after reset
- BG_COLOR, 12'h00F, background colour

Ports:
- clock  in  1  system pixel clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- display_col  in  12  horizontal counter from the timing controller
- display_row  in  11  vertical counter from the timing controller
- visible  in  1  active-video flag from the timing controller
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_dx  in  8  signed two's-complement x delta
- cmd_dy  in  8  signed two's-complement y delta
- cmd_color  in  12  new box colour
- rgb  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}
- rgb_valid  out  1  visible delayed by 2 cycles
- frame_applied  out  1  one-cycle pulse when a pending command is applied

Behaviour:
- Reset (synchronous, active-high): pos_x=INIT_X, pos_y=INIT_Y, color=INIT_COLOR, FSM=IDLE, cmd_ready=1, rgb=0, rgb_valid=0, frame_applied=0. All pipeline registers are cleared. Reset asserted mid-operation discards any pending command.
- frame_start is a combinational decode: display_col==1 && display_row==1.
- Command FSM:
  - IDLE: cmd_ready=1. If cmd_valid, latch dx, dy and color into pending registers and go to PENDING.
  - PENDING: cmd_ready=0; commands are ignored. On frame_start, apply the pending command, pulse frame_applied, and go to IDLE.
  - Accept and frame_start in the same cycle while IDLE: the command is accepted and applied at the NEXT frame_start, not the current one.
- Apply arithmetic uses 13-bit signed math:
  - nx = pos_x + sext(dx). If nx<0, nx=0. If nx>SCREEN_W-BOX_W (768), nx=768.
  - ny = pos_y + sext(dy), clamped to 0..SCREEN_H-BOX_H (568).
  - The position never wraps.
- Pixel pipeline, stage 1 (registered):
  - x = display_col - HOR_OFFSET, y = display_row - VER_OFFSET (13-bit signed).
  - in_screen = visible && 0<=x<SCREEN_W && 0<=y<SCREEN_H. display_col=840 yields x=800, which is out of screen.
  - in_box = pos_x<=x<pos_x+BOX_W && pos_y<=y<pos_y+BOX_H.
  - visible is delayed one stage.
- Pixel pipeline, stage 2 (registered):
  - rgb = in_screen ? (in_box ? color : BG_COLOR) : 12'h000.
  - rgb_valid = visible delayed.
- Latency: the input sample at cycle N appears on rgb and rgb_valid at cycle N+2.
- pos and color change only at frame_start. Pixels already in the pipeline at that edge may use the new values; this is acceptable because they fall in blanking.

Decomposition:
- Shared package vga_pkg:
  - timing constants: HOR_OFFSET, VER_OFFSET, SCREEN_W, SCREEN_H;
  - RGB width (12);
  - colour constants BLACK, BG_COLOR, WHITE;
  - FSM state encoding (IDLE, PENDING).
- One natural sub-module, vga_pos_clamp: a combinational signed add-and-clamp, instantiated once each for x and y.

Test Plan:
- Reset, then scan a full frame with cmd_valid=0:
  - rgb=12'hFFF exactly at x 384..415, y 284..315;
  - rgb=12'h00F elsewhere in screen;
  - rgb=0 whenever rgb_valid=0.
- Latency: drive display_col=40+384, display_row=1+284, visible=1 at cycle N -> rgb=12'hFFF and rgb_valid=1 at N+2, not N+1.
- Command dx=+16, dy=-4, color=12'hF00 mid-frame:
  - cmd_ready falls the next cycle;
  - the current frame is unchanged;
  - at the next frame_start, frame_applied pulses and the box is red at x 400..431, y 280..311.
- Clamp: from (384,284) apply dx=+127 four times -> x=768 (not 892). Then dx=-128 eight times -> x=0; no wrap.
- Backpressure and collision:
  - cmd_valid held high while PENDING -> no second capture.
  - Command asserted in the same cycle as frame_start from IDLE -> applied one frame later.
- Reset mid-PENDING: reset with a command pending -> box back at (384,284), colour FFF, cmd_ready=1, no frame_applied pulse.
